// File: rtl/pe_pkg.sv
// Shared definitions for the PE MAC pipeline: mode encoding and saturation bounds.
package pe_pkg;

  typedef enum logic {
    PE_MODE_OS = 1'b0,
    PE_MODE_WS = 1'b1
  } pe_mode_e;

  // Bounds are built wide and truncated by the caller to its accumulator width.
  localparam int PE_BOUND_W = 128;

  function automatic logic [PE_BOUND_W-1:0] pe_sat_max(input int w, input bit sgn);
    logic [PE_BOUND_W-1:0] one;
    one = PE_BOUND_W'(1);
    return sgn ? ((one << (w - 1)) - one) : ((one << w) - one);
  endfunction

  function automatic logic [PE_BOUND_W-1:0] pe_sat_min(input int w, input bit sgn);
    logic [PE_BOUND_W-1:0] one;
    one = PE_BOUND_W'(1);
    return sgn ? (one << (w - 1)) : '0;
  endfunction

endpackage

// File: rtl/pe_mac_pipe_if.sv
// Systolic link bundle between neighbouring PEs: row operand, column operand/weight, partial sum.
interface pe_mac_pipe_if #(
  parameter int OPND_BWIDTH = 8,
  parameter int ACC_BWIDTH  = 32
);
  logic [OPND_BWIDTH-1:0] opnd1;
  logic                   opnd1_vld;
  logic [OPND_BWIDTH-1:0] opnd2;
  logic                   opnd2_vld;
  logic [ACC_BWIDTH-1:0]  acc;
  logic                   acc_vld;

  modport master (output opnd1, opnd1_vld, opnd2, opnd2_vld, acc, acc_vld);
  modport slave  (input  opnd1, opnd1_vld, opnd2, opnd2_vld, acc, acc_vld);
endinterface

// File: rtl/pe_mul_stage.sv
// Registered multiply stage: product of the captured operands, extended to accumulator width.
module pe_mul_stage #(
  parameter int OPND_BWIDTH = 8,
  parameter int ACC_BWIDTH  = 32,
  parameter int SIGNED      = 1
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   en,
  input  logic                   kill,
  input  logic [OPND_BWIDTH-1:0] a,
  input  logic [OPND_BWIDTH-1:0] b,
  input  logic                   a_vld,
  input  logic                   b_vld,
  output logic [ACC_BWIDTH-1:0]  prod,
  output logic                   prod_vld
);
  localparam int PW = 2 * OPND_BWIDTH;

  logic [ACC_BWIDTH-1:0] prod_ext;

  generate
    if (SIGNED != 0) begin : g_sgn
      logic signed [PW-1:0] ae, be, p;
      assign ae       = {{OPND_BWIDTH{a[OPND_BWIDTH-1]}}, a};
      assign be       = {{OPND_BWIDTH{b[OPND_BWIDTH-1]}}, b};
      assign p        = ae * be;
      assign prod_ext = ACC_BWIDTH'(p);
    end else begin : g_uns
      logic [PW-1:0] p;
      assign p        = {{OPND_BWIDTH{1'b0}}, a} * {{OPND_BWIDTH{1'b0}}, b};
      assign prod_ext = ACC_BWIDTH'(p);
    end
  endgenerate

  always_ff @(posedge CLK) begin
    if (RST) begin
      prod     <= '0;
      prod_vld <= 1'b0;
    end else if (en) begin
      prod     <= prod_ext;
      prod_vld <= a_vld & b_vld & ~kill;
    end
  end

endmodule

// File: rtl/pe_mac_pipe.sv
// Systolic PE: operand capture, registered multiply, accumulate in OS or WS mode
// with optional saturation and a sticky overflow flag.
module pe_mac_pipe
  import pe_pkg::*;
#(
  parameter int OPND_BWIDTH = 8,
  parameter int ACC_BWIDTH  = 32,
  parameter int SIGNED      = 1,
  parameter int SAT_EN      = 0
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   ROWE,
  input  logic                   COLE,
  input  logic                   MODE,
  input  logic                   COMPUTE,
  input  logic                   FLUSH,
  input  logic                   LOAD_W,
  input  logic                   CLR_ACC,
  input  logic [OPND_BWIDTH-1:0] OPND1_in,
  input  logic                   OPND1_VLD_in,
  input  logic [OPND_BWIDTH-1:0] OPND2_in,
  input  logic                   OPND2_VLD_in,
  input  logic [ACC_BWIDTH-1:0]  ACC_in,
  input  logic                   ACC_VLD_in,
  output logic [OPND_BWIDTH-1:0] OPND1_out,
  output logic                   OPND1_VLD_out,
  output logic [OPND_BWIDTH-1:0] OPND2_out,
  output logic                   OPND2_VLD_out,
  output logic [ACC_BWIDTH-1:0]  ACC_out,
  output logic                   ACC_VLD_out,
  output logic                   OVF
);
  localparam int AW = ACC_BWIDTH;
  localparam logic [AW-1:0] ACC_MAX = AW'(pe_sat_max(AW, SIGNED != 0));
  localparam logic [AW-1:0] ACC_MIN = AW'(pe_sat_min(AW, SIGNED != 0));

  generate
    if (ACC_BWIDTH < 2 * OPND_BWIDTH) begin : g_bad_width
      $error("pe_mac_pipe: ACC_BWIDTH must be >= 2*OPND_BWIDTH");
    end
  endgenerate

  logic en, ws, flush_os, nop, adv;
  logic [OPND_BWIDTH-1:0] opnd1_reg, opnd2_reg, weight;
  logic opnd1_vld, opnd2_vld, w_vld;
  logic [AW-1:0] prod, acc_reg;
  logic prod_vld, acc_vld, ovf_q;

  // FLUSH only means something in OS; COMPUTE+FLUSH there freezes the whole PE.
  assign en       = ROWE & COLE;
  assign ws       = (pe_mode_e'(MODE) == PE_MODE_WS);
  assign flush_os = FLUSH & ~ws;
  assign nop      = COMPUTE & flush_os;
  assign adv      = en & ~nop;

  // In WS the weight is snapshotted into opnd2_reg at capture, so a same-cycle
  // LOAD_W affects only later operands.
  always_ff @(posedge CLK) begin
    if (RST) begin
      opnd1_reg <= '0;
      opnd1_vld <= 1'b0;
      opnd2_reg <= '0;
      opnd2_vld <= 1'b0;
      weight    <= '0;
      w_vld     <= 1'b0;
    end else if (adv) begin
      if (COMPUTE) begin
        opnd1_reg <= OPND1_in;
        opnd1_vld <= OPND1_VLD_in;
        opnd2_reg <= ws ? weight : OPND2_in;
        opnd2_vld <= ws ? w_vld : OPND2_VLD_in;
      end else begin
        opnd1_vld <= 1'b0;
        opnd2_vld <= 1'b0;
      end
      if (LOAD_W) begin
        weight <= OPND2_in;
        w_vld  <= OPND2_VLD_in;
      end
    end
  end

  pe_mul_stage #(
    .OPND_BWIDTH (OPND_BWIDTH),
    .ACC_BWIDTH  (ACC_BWIDTH),
    .SIGNED      (SIGNED)
  ) u_mul (
    .CLK      (CLK),
    .RST      (RST),
    .en       (adv),
    .kill     (flush_os),
    .a        (opnd1_reg),
    .b        (opnd2_reg),
    .a_vld    (opnd1_vld),
    .b_vld    (opnd2_vld),
    .prod     (prod),
    .prod_vld (prod_vld)
  );

  logic [AW-1:0] addend, clamp, sum_res;
  logic [AW:0]   sum_full;
  logic          sum_ovf;

  // One extra bit of sum carries the true result for overflow detection.
  always_comb begin
    addend = ws ? ACC_in : acc_reg;
    if (SIGNED != 0) begin
      sum_full = {addend[AW-1], addend} + {prod[AW-1], prod};
      sum_ovf  = sum_full[AW] ^ sum_full[AW-1];
      clamp    = sum_full[AW] ? ACC_MIN : ACC_MAX;
    end else begin
      sum_full = {1'b0, addend} + {1'b0, prod};
      sum_ovf  = sum_full[AW];
      clamp    = ACC_MAX;
    end
    sum_res = (sum_ovf && (SAT_EN != 0)) ? clamp : sum_full[AW-1:0];
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      acc_reg <= '0;
      acc_vld <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (adv) begin
      if (CLR_ACC) begin
        acc_reg <= prod_vld ? prod : '0;
        acc_vld <= prod_vld;
        ovf_q   <= 1'b0;
      end else if (flush_os) begin
        acc_reg <= ACC_in;
        acc_vld <= ACC_VLD_in;
      end else if (prod_vld) begin
        acc_reg <= sum_res;
        acc_vld <= ws ? ACC_VLD_in : 1'b1;
        if (sum_ovf) ovf_q <= 1'b1;
      end else if (ws) begin
        acc_reg <= ACC_in;
        acc_vld <= 1'b0;
      end
    end
  end

  assign OPND1_out     = opnd1_reg;
  assign OPND1_VLD_out = opnd1_vld;
  assign OPND2_out     = ws ? weight : opnd2_reg;
  assign OPND2_VLD_out = ws ? w_vld : opnd2_vld;
  assign ACC_out       = acc_reg;
  assign ACC_VLD_out   = acc_vld;
  assign OVF           = ovf_q;

endmodule

// File: tb/tb_pe_mac_pipe.sv
// Directed bench for pe_mac_pipe: three configurations share one stimulus stream.
module tb_pe_mac_pipe;
  logic CLK, RST, ROWE, COLE, MODE, COMPUTE, FLUSH, LOAD_W, CLR_ACC;

  pe_mac_pipe_if #(.OPND_BWIDTH(8), .ACC_BWIDTH(32)) lnk_in ();
  pe_mac_pipe_if #(.OPND_BWIDTH(8), .ACC_BWIDTH(32)) lnk_o0 ();

  logic OVF0, OVF1, OVF2;
  logic [7:0]  o1_1, o2_1, o1_2, o2_2;
  logic        o1v_1, o2v_1, o1v_2, o2v_2, accv_1, accv_2;
  logic [15:0] acc_1;
  logic [31:0] acc_2;

  int n_chk = 0;
  int n_err = 0;

  // dut0: signed, wrap, 32-bit
  pe_mac_pipe #(.OPND_BWIDTH(8), .ACC_BWIDTH(32), .SIGNED(1), .SAT_EN(0)) dut0 (
    .CLK(CLK), .RST(RST), .ROWE(ROWE), .COLE(COLE), .MODE(MODE), .COMPUTE(COMPUTE),
    .FLUSH(FLUSH), .LOAD_W(LOAD_W), .CLR_ACC(CLR_ACC),
    .OPND1_in(lnk_in.opnd1), .OPND1_VLD_in(lnk_in.opnd1_vld),
    .OPND2_in(lnk_in.opnd2), .OPND2_VLD_in(lnk_in.opnd2_vld),
    .ACC_in(lnk_in.acc), .ACC_VLD_in(lnk_in.acc_vld),
    .OPND1_out(lnk_o0.opnd1), .OPND1_VLD_out(lnk_o0.opnd1_vld),
    .OPND2_out(lnk_o0.opnd2), .OPND2_VLD_out(lnk_o0.opnd2_vld),
    .ACC_out(lnk_o0.acc), .ACC_VLD_out(lnk_o0.acc_vld), .OVF(OVF0));

  // dut1: signed, saturating, 16-bit
  pe_mac_pipe #(.OPND_BWIDTH(8), .ACC_BWIDTH(16), .SIGNED(1), .SAT_EN(1)) dut1 (
    .CLK(CLK), .RST(RST), .ROWE(ROWE), .COLE(COLE), .MODE(MODE), .COMPUTE(COMPUTE),
    .FLUSH(FLUSH), .LOAD_W(LOAD_W), .CLR_ACC(CLR_ACC),
    .OPND1_in(lnk_in.opnd1), .OPND1_VLD_in(lnk_in.opnd1_vld),
    .OPND2_in(lnk_in.opnd2), .OPND2_VLD_in(lnk_in.opnd2_vld),
    .ACC_in(lnk_in.acc[15:0]), .ACC_VLD_in(lnk_in.acc_vld),
    .OPND1_out(o1_1), .OPND1_VLD_out(o1v_1), .OPND2_out(o2_1), .OPND2_VLD_out(o2v_1),
    .ACC_out(acc_1), .ACC_VLD_out(accv_1), .OVF(OVF1));

  // dut2: unsigned, wrap, 32-bit
  pe_mac_pipe #(.OPND_BWIDTH(8), .ACC_BWIDTH(32), .SIGNED(0), .SAT_EN(0)) dut2 (
    .CLK(CLK), .RST(RST), .ROWE(ROWE), .COLE(COLE), .MODE(MODE), .COMPUTE(COMPUTE),
    .FLUSH(FLUSH), .LOAD_W(LOAD_W), .CLR_ACC(CLR_ACC),
    .OPND1_in(lnk_in.opnd1), .OPND1_VLD_in(lnk_in.opnd1_vld),
    .OPND2_in(lnk_in.opnd2), .OPND2_VLD_in(lnk_in.opnd2_vld),
    .ACC_in(lnk_in.acc), .ACC_VLD_in(lnk_in.acc_vld),
    .OPND1_out(o1_2), .OPND1_VLD_out(o1v_2), .OPND2_out(o2_2), .OPND2_VLD_out(o2v_2),
    .ACC_out(acc_2), .ACC_VLD_out(accv_2), .OVF(OVF2));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    ROWE = 1'b1; COLE = 1'b1; COMPUTE = 1'b0; FLUSH = 1'b0; LOAD_W = 1'b0; CLR_ACC = 1'b0;
    lnk_in.opnd1 = '0; lnk_in.opnd1_vld = 1'b0;
    lnk_in.opnd2 = '0; lnk_in.opnd2_vld = 1'b0;
    lnk_in.acc = '0;   lnk_in.acc_vld = 1'b0;
  endtask

  task automatic op(input logic [7:0] a, input logic [7:0] b, input logic v);
    COMPUTE = 1'b1;
    lnk_in.opnd1 = a; lnk_in.opnd1_vld = v;
    lnk_in.opnd2 = b; lnk_in.opnd2_vld = v;
    tick();
  endtask

  task automatic bubble();
    COMPUTE = 1'b0;
    lnk_in.opnd1_vld = 1'b0; lnk_in.opnd2_vld = 1'b0;
    tick();
  endtask

  task automatic do_reset();
    RST = 1'b1; tick(); tick(); RST = 1'b0;
  endtask

  typedef struct {
    logic [7:0]  op1;
    logic [7:0]  op2;
    logic        vld;
    logic [31:0] acc;
    logic        acc_vld;
  } vec_t;

  vec_t tv[6];

  initial begin
    // OS signed stream; expected ACC lags the operand row by two edges
    tv[0] = '{8'd3,   8'd4,   1'b1, 32'd0,         1'b0};
    tv[1] = '{8'hFE,  8'd5,   1'b1, 32'd0,         1'b0};
    tv[2] = '{8'h7F,  8'h80,  1'b1, 32'd12,        1'b1};
    tv[3] = '{8'd0,   8'd0,   1'b0, 32'd2,         1'b1};
    tv[4] = '{8'd0,   8'd0,   1'b0, 32'hFFFF_C082, 1'b1};
    tv[5] = '{8'd0,   8'd0,   1'b0, 32'hFFFF_C082, 1'b1};

    idle(); MODE = 1'b0; RST = 1'b1;
    // reset wins over every command
    COMPUTE = 1'b1; LOAD_W = 1'b1; lnk_in.opnd1 = 8'd9; lnk_in.opnd1_vld = 1'b1;
    lnk_in.opnd2 = 8'd9; lnk_in.opnd2_vld = 1'b1;
    tick(); tick();
    chk("rst_acc", lnk_o0.acc, 32'd0);
    chk("rst_acc_vld", 32'(lnk_o0.acc_vld), 32'd0);
    chk("rst_o1", 32'(lnk_o0.opnd1), 32'd0);
    chk("rst_o2", 32'(lnk_o0.opnd2), 32'd0);
    chk("rst_ovf", 32'(OVF0), 32'd0);
    RST = 1'b0; idle();

    for (int i = 0; i < 6; i++) begin
      op(tv[i].op1, tv[i].op2, tv[i].vld);
      chk($sformatf("os_acc[%0d]", i), lnk_o0.acc, tv[i].acc);
      chk($sformatf("os_acc_vld[%0d]", i), 32'(lnk_o0.acc_vld), 32'(tv[i].acc_vld));
      chk($sformatf("os_o1[%0d]", i), {23'd0, lnk_o0.opnd1_vld, lnk_o0.opnd1}, {23'd0, tv[i].vld, tv[i].op1});
    end

    // OS flush: load 50, flush in 9, in-flight 2*3 must vanish
    COMPUTE = 1'b0; CLR_ACC = 1'b1; tick(); CLR_ACC = 1'b0;
    op(8'd5, 8'd10, 1'b1); bubble(); bubble();
    chk("os_acc50", lnk_o0.acc, 32'd50);
    op(8'd2, 8'd3, 1'b1);
    COMPUTE = 1'b0; lnk_in.opnd1_vld = 1'b0; lnk_in.opnd2_vld = 1'b0;
    FLUSH = 1'b1; lnk_in.acc = 32'd9; lnk_in.acc_vld = 1'b1; tick();
    chk("flush_acc", lnk_o0.acc, 32'd9);
    chk("flush_vld", 32'(lnk_o0.acc_vld), 32'd1);
    FLUSH = 1'b0; lnk_in.acc_vld = 1'b0; bubble(); bubble();
    chk("flush_drop", lnk_o0.acc, 32'd9);

    // COMPUTE + FLUSH is a no-op
    COMPUTE = 1'b1; FLUSH = 1'b1; lnk_in.opnd1 = 8'd1; lnk_in.opnd1_vld = 1'b1;
    lnk_in.opnd2 = 8'd1; lnk_in.opnd2_vld = 1'b1; lnk_in.acc = 32'd77; lnk_in.acc_vld = 1'b1;
    tick(); tick();
    chk("nop_acc", lnk_o0.acc, 32'd9);
    chk("nop_o1", {23'd0, lnk_o0.opnd1_vld, lnk_o0.opnd1}, {23'd0, 1'b0, 8'd2});
    FLUSH = 1'b0; lnk_in.acc_vld = 1'b0; bubble(); bubble();
    chk("nop_after", lnk_o0.acc, 32'd9);

    // ROWE=0 freezes everything, CLR_ACC and LOAD_W included
    op(8'd4, 8'd4, 1'b1);
    ROWE = 1'b0; COMPUTE = 1'b1; CLR_ACC = 1'b1; LOAD_W = 1'b1;
    lnk_in.opnd1 = 8'd9; lnk_in.opnd2 = 8'd9; lnk_in.opnd1_vld = 1'b1; lnk_in.opnd2_vld = 1'b1;
    tick(); tick(); tick();
    chk("frz_acc", lnk_o0.acc, 32'd9);
    chk("frz_o1", {23'd0, lnk_o0.opnd1_vld, lnk_o0.opnd1}, {23'd0, 1'b1, 8'd4});
    chk("frz_o2", 32'(lnk_o0.opnd2), 32'd4);
    ROWE = 1'b1; CLR_ACC = 1'b0; LOAD_W = 1'b0; bubble(); bubble();
    chk("frz_resume", lnk_o0.acc, 32'd25);

    // reset mid-accumulation, then first-operand latency
    op(8'd2, 8'd2, 1'b1); op(8'd2, 8'd2, 1'b1);
    RST = 1'b1; tick(); RST = 1'b0;
    chk("rstmid_acc", lnk_o0.acc, 32'd0);
    chk("rstmid_vld", {30'd0, lnk_o0.acc_vld, lnk_o0.opnd1_vld}, 32'd0);
    chk("rstmid_o1", 32'(lnk_o0.opnd1), 32'd0);
    op(8'd3, 8'd3, 1'b1);
    chk("lat_n", lnk_o0.acc, 32'd0);
    bubble();
    chk("lat_n1_vld", 32'(lnk_o0.acc_vld), 32'd0);
    bubble();
    chk("lat_n2", lnk_o0.acc, 32'd9);
    chk("lat_n2_vld", 32'(lnk_o0.acc_vld), 32'd1);

    // WS: load weight 7, then 3*7 + 10
    idle(); do_reset(); MODE = 1'b1;
    LOAD_W = 1'b1; lnk_in.opnd2 = 8'd7; lnk_in.opnd2_vld = 1'b1; tick();
    LOAD_W = 1'b0; lnk_in.opnd2 = 8'd0; lnk_in.opnd2_vld = 1'b0;
    chk("ws_w", {23'd0, lnk_o0.opnd2_vld, lnk_o0.opnd2}, {23'd0, 1'b1, 8'd7});
    lnk_in.acc = 32'd10; lnk_in.acc_vld = 1'b1;
    op(8'd3, 8'd0, 1'b1);
    bubble();
    chk("ws_pass", {lnk_o0.acc[30:0], lnk_o0.acc_vld}, {31'd10, 1'b0});
    bubble();
    chk("ws_acc", lnk_o0.acc, 32'd31);
    chk("ws_acc_vld", 32'(lnk_o0.acc_vld), 32'd1);
    chk("ws_o2", 32'(lnk_o0.opnd2), 32'd7);

    // WS: LOAD_W with COMPUTE uses the old weight
    lnk_in.acc = 32'd0; LOAD_W = 1'b1; COMPUTE = 1'b1;
    lnk_in.opnd1 = 8'd5; lnk_in.opnd1_vld = 1'b1; lnk_in.opnd2 = 8'd2; lnk_in.opnd2_vld = 1'b1;
    tick(); LOAD_W = 1'b0;
    bubble(); bubble();
    chk("ws_preload", lnk_o0.acc, 32'd35);
    chk("ws_neww", 32'(lnk_o0.opnd2), 32'd2);

    // unsigned 255*255 vs signed (-1)*(-1)
    idle(); do_reset(); MODE = 1'b0;
    op(8'hFF, 8'hFF, 1'b1); bubble(); bubble();
    chk("uns_acc", acc_2, 32'd65025);
    chk("uns_ovf", 32'(OVF2), 32'd0);
    chk("sgn_m1", lnk_o0.acc, 32'd1);

    // saturation: 3 x 16129 clamps at 32767 in 16 bits, wraps-free in 32 bits
    idle(); do_reset();
    op(8'd127, 8'd127, 1'b1); op(8'd127, 8'd127, 1'b1); op(8'd127, 8'd127, 1'b1);
    bubble(); bubble(); bubble(); bubble();
    chk("sat_pos", 32'(acc_1), 32'd32767);
    chk("sat_ovf", 32'(OVF1), 32'd1);
    chk("wide_acc", lnk_o0.acc, 32'd48387);
    chk("wide_ovf", 32'(OVF0), 32'd0);
    op(8'd127, 8'd127, 1'b1); bubble();
    CLR_ACC = 1'b1; tick(); CLR_ACC = 1'b0;
    chk("clr_acc", 32'(acc_1), 32'd16129);
    chk("clr_ovf", 32'(OVF1), 32'd0);
    chk("clr_vld", 32'(accv_1), 32'd1);

    // negative clamp: 16129 - 4*16256
    for (int i = 0; i < 4; i++) op(8'h80, 8'd127, 1'b1);
    bubble(); bubble();
    chk("sat_neg", 32'(acc_1), 32'h0000_8000);
    chk("sat_neg_ovf", 32'(OVF1), 32'd1);
    chk("wide_neg", lnk_o0.acc, 32'(-48895));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
